// File: rtl/name_entry_buffer.sv
// rtl/name_entry_buffer.sv - player-name entry buffer: HID keycode to ASCII store,
// registered glyph read port, length/cursor tracking and blinking cursor.
module name_entry_buffer #(
  parameter int          ADDR_W       = 3,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [7:0]  BLANK        = 8'h20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        key_in,
  input  logic              clear,
  input  logic              frame_tick,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_glyph,
  output logic [ADDR_W:0]   length,
  output logic              full,
  output logic [ADDR_W:0]   cursor_pos,
  output logic              cursor_on
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(BLINK_FRAMES - 1);

  logic [7:0]        slots_q [DEPTH];
  logic [7:0]        rd_glyph_q;
  logic [ADDR_W:0]   length_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              blink_q;

  logic              key_valid;
  logic [7:0]        glyph;
  logic              accept;
  logic [ADDR_W:0]   addr_end;

  always_comb begin
    key_valid = 1'b1;
    glyph     = BLANK;
    if (key_in >= 8'h04 && key_in <= 8'h1D) begin
      glyph = key_in + 8'h3D;
    end else if (key_in >= 8'h1E && key_in <= 8'h26) begin
      glyph = key_in + 8'h13;
    end else if (key_in == 8'h27) begin
      glyph = 8'h30;
    end else if (key_in == 8'h2C) begin
      glyph = 8'h20;
    end else begin
      key_valid = 1'b0;
    end
  end

  assign accept   = we && key_valid;
  assign addr_end = {1'b0, addr} + 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= BLANK;
      length_q <= '0;
      cnt_q    <= '0;
      blink_q  <= 1'b1;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= BLANK;
      length_q <= '0;
      cnt_q    <= '0;
      blink_q  <= 1'b1;
    end else if (accept) begin
      // Typing restarts the blink so the cursor is visible right after a keystroke.
      slots_q[addr] <= glyph;
      if (addr_end > length_q) length_q <= addr_end;
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else if (frame_tick) begin
      if (cnt_q == CNT_TERM) begin
        cnt_q   <= '0;
        blink_q <= ~blink_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) rd_glyph_q <= BLANK;
    else       rd_glyph_q <= slots_q[rd_addr];
  end

  assign rd_glyph   = rd_glyph_q;
  assign length     = length_q;
  assign full       = (length_q == (ADDR_W + 1)'(DEPTH));
  assign cursor_pos = length_q;
  assign cursor_on  = blink_q && !full;

endmodule

// File: tb/tb_name_entry_buffer.sv
// tb/tb_name_entry_buffer.sv - directed self-checking bench for name_entry_buffer.
module tb_name_entry_buffer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       we;
  logic [2:0] addr;
  logic [7:0] key_in;
  logic       clear;
  logic       frame_tick;
  logic [2:0] rd_addr;
  logic [7:0] rd_glyph;
  logic [3:0] length;
  logic       full;
  logic [3:0] cursor_pos;
  logic       cursor_on;

  int tests_run = 0;
  int tests_failed = 0;

  name_entry_buffer #(.ADDR_W(3), .BLINK_FRAMES(30), .BLANK(8'h20)) dut (
    .Clk(Clk), .Reset(Reset), .we(we), .addr(addr), .key_in(key_in),
    .clear(clear), .frame_tick(frame_tick), .rd_addr(rd_addr),
    .rd_glyph(rd_glyph), .length(length), .full(full),
    .cursor_pos(cursor_pos), .cursor_on(cursor_on)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_slot(input string tag, input logic [2:0] a, input logic [7:0] exp);
    rd_addr = a;
    step();
    check(tag, {24'd0, rd_glyph}, {24'd0, exp});
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; we = 1'b0; addr = '0; key_in = '0; clear = 1'b0;
    frame_tick = 1'b0; rd_addr = '0;
    step(); step();
    Reset = 1'b0;

    check("reset_rd_glyph", {24'd0, rd_glyph}, 32'h20);
    check("reset_length", {28'd0, length}, 32'd0);
    check("reset_full", {31'd0, full}, 32'd0);
    check("reset_cursor_pos", {28'd0, cursor_pos}, 32'd0);
    check("reset_cursor_on", {31'd0, cursor_on}, 32'd1);
    for (int i = 0; i < 8; i++) check_slot("reset_slot", 3'(i), 8'h20);

    // burst writes: slot0 'A' x3, slot1 '1' x2
    we = 1'b1; addr = 3'd0; key_in = 8'h04;
    step(); step(); step();
    addr = 3'd1; key_in = 8'h1E;
    step(); step();
    we = 1'b0;
    check_slot("burst_slot0", 3'd0, 8'h41);
    check_slot("burst_slot1", 3'd1, 8'h31);
    check("burst_length", {28'd0, length}, 32'd2);
    check("burst_cursor_pos", {28'd0, cursor_pos}, 32'd2);

    // invalid keys dropped
    we = 1'b1; addr = 3'd2; key_in = 8'h28; step();
    key_in = 8'h00; step();
    we = 1'b0;
    check_slot("invalid_slot2", 3'd2, 8'h20);
    check("invalid_length", {28'd0, length}, 32'd2);

    // lower-slot write keeps length; '0' and space translation
    we = 1'b1; addr = 3'd0; key_in = 8'h27; step();
    addr = 3'd4; key_in = 8'h2C; step();
    we = 1'b0;
    check_slot("zero_slot0", 3'd0, 8'h30);
    check("skip_length", {28'd0, length}, 32'd5);
    check_slot("skip_slot3", 3'd3, 8'h20);
    check_slot("space_slot4", 3'd4, 8'h20);

    // fill all slots with 'Z'
    we = 1'b1; key_in = 8'h1D;
    for (int i = 0; i < 8; i++) begin addr = 3'(i); step(); end
    we = 1'b0;
    for (int i = 0; i < 8; i++) check_slot("full_slot", 3'(i), 8'h5A);
    check("full_length", {28'd0, length}, 32'd8);
    check("full_flag", {31'd0, full}, 32'd1);
    check("full_cursor_pos", {28'd0, cursor_pos}, 32'd8);
    for (int t = 1; t <= 100; t++) begin
      tick();
      check("full_cursor_off", {31'd0, cursor_on}, 32'd0);
    end

    // blink with no writes
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_length", {28'd0, length}, 32'd0);
    check("clear_cursor_on", {31'd0, cursor_on}, 32'd1);
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (t == 29) check("blink_t29", {31'd0, cursor_on}, 32'd1);
      if (t == 30) check("blink_t30", {31'd0, cursor_on}, 32'd0);
      if (t == 59) check("blink_t59", {31'd0, cursor_on}, 32'd0);
      if (t == 60) check("blink_t60", {31'd0, cursor_on}, 32'd1);
    end

    // write coinciding with tick 45 restarts the blink
    clear = 1'b1; step(); clear = 1'b0;
    for (int t = 1; t <= 75; t++) begin
      if (t == 45) begin we = 1'b1; addr = 3'd0; key_in = 8'h06; end
      tick();
      we = 1'b0;
      if (t == 44) check("rblink_t44", {31'd0, cursor_on}, 32'd0);
      if (t == 45) check("rblink_t45", {31'd0, cursor_on}, 32'd1);
      if (t == 74) check("rblink_t74", {31'd0, cursor_on}, 32'd1);
      if (t == 75) check("rblink_t75", {31'd0, cursor_on}, 32'd0);
    end
    check("rblink_length", {28'd0, length}, 32'd1);

    // clear beats a same-cycle write
    clear = 1'b1; we = 1'b1; addr = 3'd3; key_in = 8'h05; step();
    clear = 1'b0; we = 1'b0;
    for (int i = 0; i < 8; i++) check_slot("clrwr_slot", 3'(i), 8'h20);
    check("clrwr_length", {28'd0, length}, 32'd0);

    // read-during-write returns old value
    we = 1'b1; addr = 3'd0; key_in = 8'h04; rd_addr = 3'd0; step();
    we = 1'b0;
    check("rdw_old", {24'd0, rd_glyph}, 32'h20);
    step();
    check("rdw_new", {24'd0, rd_glyph}, 32'h41);

    // reset wins over clear and restores blank state
    Reset = 1'b1; clear = 1'b1; step();
    Reset = 1'b0; clear = 1'b0;
    check("rst2_length", {28'd0, length}, 32'd0);
    check_slot("rst2_slot0", 3'd0, 8'h20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
